pipe_ctrl: RTL

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline hold/redirect controller: arbitrates stall requests into a hold level,
// issues PC redirects (deferring them while the bus is stalled), and runs a bus watchdog.
module pipe_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int TIMEOUT      = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_flag_i,
  input  logic [31:0] jump_addr_i,
  input  logic        int_assert_i,
  input  logic [31:0] int_addr_i,
  input  logic        hold_flag_ex_i,
  input  logic        load_use_i,
  input  logic        rib_hold_i,
  output logic [2:0]  hold_flag_o,
  output logic        jump_flag_o,
  output logic [31:0] jump_addr_o,
  output logic        bus_timeout_o,
  output logic [31:0] stall_cycles_o
);

  localparam logic [2:0] HOLD_NONE = 3'd0;
  localparam logic [2:0] HOLD_PC   = 3'd1;
  localparam logic [2:0] HOLD_IF   = 3'd2;
  localparam logic [2:0] HOLD_ID   = 3'd3;
  localparam logic [1:0] FCNT_INIT = (FLUSH_CYCLES > 0) ? 2'(FLUSH_CYCLES - 1) : 2'd0;
  localparam logic [7:0] WD_MAX    = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_PEND  = 2'd1,
    S_FLUSH = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  fcnt_q, fcnt_d;
  logic [31:0] pend_addr_q, pend_addr_d;
  logic [7:0]  wd_q, wd_d;
  logic [31:0] stall_q, stall_d;
  logic        issue_s;
  logic [31:0] issue_addr_s;
  logic [2:0]  hold_s;
  logic        redirect_s;
  logic [31:0] target_s;

  assign redirect_s = int_assert_i | jump_flag_i;
  assign target_s   = int_assert_i ? int_addr_i : jump_addr_i;

  // Redirect FSM: issue immediately when the bus is free, otherwise park the target
  always_comb begin
    state_d      = state_q;
    fcnt_d       = fcnt_q;
    pend_addr_d  = pend_addr_q;
    issue_s      = 1'b0;
    issue_addr_s = 32'd0;
    case (state_q)
      S_RUN, S_FLUSH: begin
        if (redirect_s) begin
          if (!rib_hold_i) begin
            issue_s      = 1'b1;
            issue_addr_s = target_s;
          end else begin
            pend_addr_d = target_s;
            state_d     = S_PEND;
          end
        end else if (state_q == S_FLUSH) begin
          if (fcnt_q == 2'd0) begin
            state_d = S_RUN;
          end else begin
            fcnt_d = fcnt_q - 2'd1;
          end
        end else begin
          state_d = S_RUN;
        end
      end
      S_PEND: begin
        // A late interrupt wins over the parked target; a late jump is dropped
        if (!rib_hold_i) begin
          issue_s      = 1'b1;
          issue_addr_s = int_assert_i ? int_addr_i : pend_addr_q;
        end else if (int_assert_i) begin
          pend_addr_d = int_addr_i;
        end else begin
          pend_addr_d = pend_addr_q;
        end
      end
      default: begin
        state_d = S_RUN;
        fcnt_d  = 2'd0;
      end
    endcase
    if (issue_s) begin
      state_d = (FLUSH_CYCLES > 0) ? S_FLUSH : S_RUN;
      fcnt_d  = FCNT_INIT;
    end else begin
      fcnt_d = fcnt_d;
    end
  end

  // Hold level is the highest-numbered active request
  always_comb begin
    hold_s = HOLD_NONE;
    if (jump_flag_i || int_assert_i || hold_flag_ex_i ||
        state_q == S_PEND || state_q == S_FLUSH) begin
      hold_s = HOLD_ID;
    end else if (load_use_i) begin
      hold_s = HOLD_IF;
    end else if (rib_hold_i) begin
      hold_s = HOLD_PC;
    end else begin
      hold_s = HOLD_NONE;
    end
  end

  // Watchdog saturates at the threshold so the pulse fires once per stall episode
  always_comb begin
    wd_d    = 8'd0;
    stall_d = stall_q + ((hold_s != HOLD_NONE) ? 32'd1 : 32'd0);
    if (rib_hold_i) begin
      wd_d = (wd_q == WD_MAX) ? wd_q : wd_q + 8'd1;
    end else begin
      wd_d = 8'd0;
    end
  end

  // State, pending target, watchdog and stall counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_RUN;
      fcnt_q      <= 2'd0;
      pend_addr_q <= 32'd0;
      wd_q        <= 8'd0;
      stall_q     <= 32'd0;
    end else begin
      state_q     <= state_d;
      fcnt_q      <= fcnt_d;
      pend_addr_q <= pend_addr_d;
      wd_q        <= wd_d;
      stall_q     <= stall_d;
    end
  end

  assign hold_flag_o    = rst ? HOLD_ID : hold_s;
  assign jump_flag_o    = issue_s & ~rst;
  assign jump_addr_o    = jump_flag_o ? issue_addr_s : 32'd0;
  assign bus_timeout_o  = ~rst & rib_hold_i & (wd_q == WD_MAX - 8'd1);
  assign stall_cycles_o = stall_q;

endmodule
